// File: rtl/job_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : job_ctrl_fsm
// Description : Job-control FSM sitting between a host/sequencer and a
//               datapath engine. A job passes through a timed INIT phase and
//               a RUN phase guarded by an optional watchdog. Engine errors and
//               watchdog expiries are retried up to MAX_RETRY times. The host
//               may abort at any point during INIT/RUN. DONE and ERROR are
//               held until the host acknowledges them.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start           - job request (IDLE only)
//               done, error     - engine completion / error (RUN only)
//               abort           - host abort (INIT/RUN)
//               ack             - host acknowledge (DONE/ERROR)
//               busy            - INIT or RUN
//               valid           - DONE
//               fault           - ERROR
//               fault_code      - 00 none, 01 error, 10 timeout, 11 abort
//               retry_cnt       - retries consumed by the current job
//               state_o         - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module job_ctrl_fsm #(
    parameter int INIT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRY      = 2,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       done,
    input  logic       error,
    input  logic       abort,
    input  logic       ack,
    output logic       busy,
    output logic       valid,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [1:0] c_CODE_NONE    = 2'b00;
    localparam logic [1:0] c_CODE_ERROR   = 2'b01;
    localparam logic [1:0] c_CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] c_CODE_ABORT   = 2'b11;

    localparam logic [CNT_W-1:0] c_INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    // Guarded so that a disabled watchdog never produces a negative constant.
    localparam logic [CNT_W-1:0] c_TO_LAST   =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));
    localparam bit               c_WD_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [3:0]       c_MAX_RETRY = 4'(MAX_RETRY);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry;
    logic [1:0]       r_code;

    logic w_init_last;
    logic w_timeout;
    logic w_can_retry;

    assign w_init_last = (r_cnt == c_INIT_LAST);
    assign w_timeout   = c_WD_EN && (r_cnt == c_TO_LAST);
    assign w_can_retry = (r_retry < c_MAX_RETRY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_retry <= 4'd0;
            r_code  <= c_CODE_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state <= S_INIT;
                        r_retry <= 4'd0;
                        r_code  <= c_CODE_NONE;
                    end
                end

                S_INIT: begin
                    if (abort) begin
                        r_state <= S_ERROR;
                        r_code  <= c_CODE_ABORT;
                        r_cnt   <= '0;
                    end else if (w_init_last) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        r_state <= S_ERROR;
                        r_code  <= c_CODE_ABORT;
                        r_cnt   <= '0;
                    end else if (error || (!done && w_timeout)) begin
                        // Error and watchdog expiry share one retry budget;
                        // only the final fault code tells them apart.
                        r_cnt <= '0;
                        if (w_can_retry) begin
                            r_state <= S_INIT;
                            r_retry <= r_retry + 4'd1;
                        end else begin
                            r_state <= S_ERROR;
                            r_code  <= error ? c_CODE_ERROR : c_CODE_TIMEOUT;
                        end
                    end else if (done) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                    end
                end

                S_ERROR: begin
                    // fault_code is kept after ack; the next start clears it.
                    if (ack) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy       = (r_state == S_INIT) || (r_state == S_RUN);
    assign valid      = (r_state == S_DONE);
    assign fault      = (r_state == S_ERROR);
    assign fault_code = r_code;
    assign retry_cnt  = r_retry;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_job_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_job_ctrl_fsm
// Description : Self-checking bench for job_ctrl_fsm. Three instances with
//               different parameter sets share one stimulus stream and are
//               compared against a job-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_job_ctrl_fsm;

    logic clk;
    logic reset;
    logic start;
    logic done;
    logic error;
    logic abort;
    logic ack;

    logic       busy_a, valid_a, fault_a;
    logic [1:0] code_a;
    logic [3:0] retry_a;
    logic [2:0] state_a;
    logic       busy_b, valid_b, fault_b;
    logic [1:0] code_b;
    logic [3:0] retry_b;
    logic [2:0] state_b;
    logic       busy_c, valid_c, fault_c;
    logic [1:0] code_c;
    logic [3:0] retry_c;
    logic [2:0] state_c;

    int errors = 0;
    int checks = 0;

    // a: defaults, b: short watchdog without retry, c: watchdog disabled
    job_ctrl_fsm #(.INIT_CYCLES(4), .TIMEOUT_CYCLES(256), .MAX_RETRY(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .done(done), .error(error),
        .abort(abort), .ack(ack), .busy(busy_a), .valid(valid_a), .fault(fault_a),
        .fault_code(code_a), .retry_cnt(retry_a), .state_o(state_a));

    job_ctrl_fsm #(.INIT_CYCLES(4), .TIMEOUT_CYCLES(16), .MAX_RETRY(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .start(start), .done(done), .error(error),
        .abort(abort), .ack(ack), .busy(busy_b), .valid(valid_b), .fault(fault_b),
        .fault_code(code_b), .retry_cnt(retry_b), .state_o(state_b));

    job_ctrl_fsm #(.INIT_CYCLES(2), .TIMEOUT_CYCLES(0), .MAX_RETRY(2), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .start(start), .done(done), .error(error),
        .abort(abort), .ack(ack), .busy(busy_c), .valid(valid_c), .fault(fault_c),
        .fault_code(code_c), .retry_cnt(retry_c), .state_o(state_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    // phase uses the published state numbers; init_left counts remaining INIT
    // cycles downwards, run_age counts cycles already spent in RUN.
    typedef struct {
        int phase;
        int init_left;
        int run_age;
        int retries;
        int code;
    } mdl_t;

    mdl_t ma = '{0, 0, 0, 0, 0};
    mdl_t mb = '{0, 0, 0, 0, 0};
    mdl_t mc = '{0, 0, 0, 0, 0};

    function automatic mdl_t mstep(mdl_t m, bit rst, bit st, bit dn, bit er,
                                   bit ab, bit ak, int ic, int tc, int mr);
        mdl_t n;
        int   fail_kind;
        n = m;
        fail_kind = 0;
        if (rst) begin
            n = '{0, 0, 0, 0, 0};
            return n;
        end
        if (m.phase == 0) begin
            if (st) begin
                n.phase = 1; n.init_left = ic; n.retries = 0; n.code = 0;
            end
        end else if (m.phase == 1) begin
            if (ab) begin
                n.phase = 4; n.code = 3;
            end else begin
                n.init_left = m.init_left - 1;
                if (n.init_left == 0) begin
                    n.phase = 2; n.run_age = 0;
                end
            end
        end else if (m.phase == 2) begin
            n.run_age = m.run_age + 1;
            if (ab) begin
                n.phase = 4; n.code = 3;
            end else if (er) begin
                fail_kind = 1;
            end else if (dn) begin
                n.phase = 3;
            end else if (tc != 0 && n.run_age >= tc) begin
                fail_kind = 2;
            end
            if (fail_kind != 0) begin
                if (m.retries < mr) begin
                    n.phase = 1; n.init_left = ic; n.retries = m.retries + 1;
                end else begin
                    n.phase = 4; n.code = fail_kind;
                end
            end
        end else begin
            if (ak) n.phase = 0;
        end
        return n;
    endfunction

    function automatic logic [11:0] exp_pack(mdl_t m);
        logic b, v, f;
        b = (m.phase == 1) || (m.phase == 2);
        v = (m.phase == 3);
        f = (m.phase == 4);
        return {b, v, f, 2'(m.code), 4'(m.retries), 3'(m.phase)};
    endfunction

    always @(posedge clk) begin
        ma <= mstep(ma, reset, start, done, error, abort, ack, 4, 256, 2);
        mb <= mstep(mb, reset, start, done, error, abort, ack, 4, 16, 0);
        mc <= mstep(mc, reset, start, done, error, abort, ack, 2, 0, 2);
    end

    logic [11:0] obs_a, obs_b, obs_c;
    assign obs_a = {busy_a, valid_a, fault_a, code_a, retry_a, state_a};
    assign obs_b = {busy_b, valid_b, fault_b, code_b, retry_b, state_b};
    assign obs_c = {busy_c, valid_c, fault_c, code_c, retry_c, state_c};

    // ---------------------------------------------------------------- utils
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; done = 0; error = 0; abort = 0; ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        start = 1'($urandom); done = 1'($urandom); error = 1'($urandom);
        abort = 1'($urandom); ack = 1'($urandom);
        reset = 1;
        tick();
        tick();
        reset = 0;
        clear_inputs();
        checks++;
        if (obs_a !== 12'h000) begin
            errors++; $display("FAIL reset_a: got %h want %h", obs_a, 12'h000);
        end
        checks++;
        if (obs_b !== 12'h000 || obs_c !== 12'h000) begin
            errors++; $display("FAIL reset_bc: got %h/%h want 000/000", obs_b, obs_c);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        start = 1;
        tick();
        start = 0;
        checks++;
        if (busy_a !== 1'b1 || state_a !== 3'd1) begin
            errors++; $display("FAIL nominal_busy: got busy=%b state=%0d want 1/1", busy_a, state_a);
        end
        repeat (3) tick();
        checks++;
        if (state_a !== 3'd1) begin
            errors++; $display("FAIL nominal_init_len: got state=%0d want 1", state_a);
        end
        tick();
        checks++;
        if (state_a !== 3'd2) begin
            errors++; $display("FAIL nominal_run: got state=%0d want 2", state_a);
        end
        repeat (5) tick();
        done = 1;
        tick();
        done = 0;
        checks++;
        if ({valid_a, busy_a, state_a} !== {1'b1, 1'b0, 3'd3}) begin
            errors++; $display("FAIL nominal_done: got v=%b b=%b s=%0d want 1/0/3", valid_a, busy_a, state_a);
        end
        ack = 1;
        tick();
        ack = 0;
        checks++;
        if (state_a !== 3'd0 || valid_a !== 1'b0) begin
            errors++; $display("FAIL nominal_ack: got s=%0d v=%b want 0/0", state_a, valid_a);
        end
    endtask

    task automatic test_error_retry();
        int n;
        do_reset();
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (state_a !== 3'd2 && n < 20) begin
                checks++;
                if (busy_a !== 1'b1) begin
                    errors++; $display("FAIL retry_busy_gap: got busy=%b want 1", busy_a);
                end
                tick();
                n++;
            end
            checks++;
            if (state_a !== 3'd2) begin
                errors++; $display("FAIL retry_reach_run: got state=%0d want 2 (timed out)", state_a);
            end
            error = 1;
            tick();
            error = 0;
            checks++;
            if (k < 2) begin
                if ({state_a, retry_a, busy_a} !== {3'd1, 4'(k + 1), 1'b1}) begin
                    errors++;
                    $display("FAIL retry_step: got s=%0d r=%0d b=%b want 1/%0d/1", state_a, retry_a, busy_a, k + 1);
                end
            end else begin
                if ({state_a, fault_a, code_a, retry_a, busy_a} !== {3'd4, 1'b1, 2'b01, 4'd2, 1'b0}) begin
                    errors++;
                    $display("FAIL retry_exhaust: got s=%0d f=%b c=%b r=%0d b=%b want 4/1/01/2/0",
                             state_a, fault_a, code_a, retry_a, busy_a);
                end
            end
        end
        ack = 1;
        tick();
        ack = 0;
        checks++;
        if (state_a !== 3'd0 || code_a !== 2'b01) begin
            errors++; $display("FAIL error_ack_code_kept: got s=%0d c=%b want 0/01", state_a, code_a);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        tick();
        checks++;
        if (state_b !== 3'd2) begin
            errors++; $display("FAIL timeout_run_entry: got state=%0d want 2", state_b);
        end
        repeat (15) tick();
        checks++;
        if (state_b !== 3'd2) begin
            errors++; $display("FAIL timeout_early: got state=%0d want 2", state_b);
        end
        tick();
        checks++;
        if ({state_b, code_b, fault_b} !== {3'd4, 2'b10, 1'b1}) begin
            errors++; $display("FAIL timeout_fire: got s=%0d c=%b f=%b want 4/10/1", state_b, code_b, fault_b);
        end
        ack = 1;
        tick();
        ack = 0;
        start = 1;
        tick();
        start = 0;
        checks++;
        if (code_b !== 2'b00) begin
            errors++; $display("FAIL code_clear_on_start: got %b want 00", code_b);
        end
        repeat (4) tick();
        repeat (15) tick();
        done = 1;
        tick();
        done = 0;
        checks++;
        if (state_b !== 3'd3 || valid_b !== 1'b1) begin
            errors++; $display("FAIL timeout_done_wins: got s=%0d v=%b want 3/1", state_b, valid_b);
        end
    endtask

    task automatic test_abort();
        do_reset();
        abort = 1;
        tick();
        abort = 0;
        checks++;
        if (obs_a !== 12'h000) begin
            errors++; $display("FAIL abort_idle: got %h want 000", obs_a);
        end
        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        error = 1;
        tick();
        error = 0;
        repeat (4) tick();
        checks++;
        if ({state_a, retry_a} !== {3'd2, 4'd1}) begin
            errors++; $display("FAIL abort_setup: got s=%0d r=%0d want 2/1", state_a, retry_a);
        end
        abort = 1; error = 1; done = 1;
        tick();
        clear_inputs();
        checks++;
        if ({state_a, code_a, retry_a} !== {3'd4, 2'b11, 4'd1}) begin
            errors++; $display("FAIL abort_priority: got s=%0d c=%b r=%0d want 4/11/1", state_a, code_a, retry_a);
        end
        ack = 1;
        tick();
        ack = 0;
        start = 1;
        tick();
        start = 0;
        tick();
        abort = 1;
        tick();
        abort = 0;
        checks++;
        if ({state_a, code_a} !== {3'd4, 2'b11}) begin
            errors++; $display("FAIL abort_init: got s=%0d c=%b want 4/11", state_a, code_a);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        error = 1;
        tick();
        error = 0;
        repeat (4) tick();
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (obs_a !== 12'h000) begin
            errors++; $display("FAIL reset_mid_run: got %h want 000", obs_a);
        end
        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        done = 1;
        tick();
        done = 0;
        start = 1;
        repeat (3) tick();
        start = 0;
        checks++;
        if (state_a !== 3'd3) begin
            errors++; $display("FAIL start_in_done: got state=%0d want 3", state_a);
        end
        ack = 1;
        tick();
        ack = 0;
        checks++;
        if (state_a !== 3'd0) begin
            errors++; $display("FAIL done_ack: got state=%0d want 0", state_a);
        end
    endtask

    task automatic test_watchdog_off();
        do_reset();
        start = 1;
        tick();
        start = 0;
        repeat (2) tick();
        for (int i = 0; i < 1000; i++) begin
            checks++;
            if (state_c !== 3'd2) begin
                errors++; $display("FAIL wd_off_hold: cycle %0d got state=%0d want 2", i, state_c);
            end
            tick();
        end
        done = 1;
        tick();
        done = 0;
        checks++;
        if (state_c !== 3'd3) begin
            errors++; $display("FAIL wd_off_done: got state=%0d want 3", state_c);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            done  = ($urandom_range(0, 15) == 0);
            error = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 63) == 0);
            ack   = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (obs_a !== exp_pack(ma)) begin
                errors++; $display("FAIL random_a: cycle %0d got %h want %h", i, obs_a, exp_pack(ma));
            end
            checks++;
            if (obs_b !== exp_pack(mb)) begin
                errors++; $display("FAIL random_b: cycle %0d got %h want %h", i, obs_b, exp_pack(mb));
            end
            checks++;
            if (obs_c !== exp_pack(mc)) begin
                errors++; $display("FAIL random_c: cycle %0d got %h want %h", i, obs_c, exp_pack(mc));
            end
        end
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        #2;
        test_reset();
        test_nominal();
        test_error_retry();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        test_watchdog_off();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
